// File: rtl/pc_gen.sv
// Fetch-PC generator: sequential fetch with valid/ready, trap and branch redirects,
// a held branch redirect that survives stalls, and misaligned-target detection.
//
// state | meaning
// IDLE  | no branch redirect held
// PEND  | aligned branch target held in pend_target until stall releases
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4,
    output logic            fetch_kill,
    output logic            redirect_pending,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr
);

    localparam logic [XLEN-1:0] MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

    typedef enum logic {IDLE, PEND} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pend_target, pend_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] maddr_next;
    logic            kill_next;
    logic            mexc_next;
    logic            br_misaligned;

    assign pc_plus_4        = pc + XLEN'(4);
    assign redirect_pending = (state == PEND);
    assign br_misaligned    = (br_target & MASK) != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pend_target   <= '0;
            pc            <= RESET_VECTOR;
            fetch_valid   <= 1'b0;
            fetch_kill    <= 1'b0;
            misalign_exc  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            state         <= state_next;
            pend_target   <= pend_next;
            pc            <= pc_next;
            fetch_valid   <= 1'b1;
            fetch_kill    <= kill_next;
            misalign_exc  <= mexc_next;
            misalign_addr <= maddr_next;
        end
    end

    always_comb begin
        state_next = state;
        pend_next  = pend_target;
        pc_next    = pc;
        kill_next  = 1'b0;
        mexc_next  = 1'b0;
        maddr_next = misalign_addr;

        if (trap_valid) begin
            pc_next    = trap_target & ~MASK;
            state_next = IDLE;
            kill_next  = 1'b1;
        end else begin
            if (br_valid && br_misaligned) begin
                mexc_next  = 1'b1;
                maddr_next = br_target;
            end

            // A misaligned branch is dropped; the PC then follows pending/increment rules.
            if (br_valid && !br_misaligned) begin
                if (stall) begin
                    pend_next  = br_target;
                    state_next = PEND;
                end else begin
                    pc_next    = br_target;
                    state_next = IDLE;
                    kill_next  = 1'b1;
                end
            end else if (state == PEND && !stall) begin
                pc_next    = pend_target;
                state_next = IDLE;
                kill_next  = 1'b1;
            end else if (!stall && fetch_valid && fetch_ready) begin
                pc_next = pc_plus_4;
            end
        end
    end

endmodule
